line_raster_engine: RTL and testbench

- Parametrised successor to the single-line wireframe drawer.
- Rasterises one line segment per command using all-octant integer Bresenham.
- Emits one framebuffer write per in-bounds pixel on a valid/ready pixel stream, which feeds the AXI master write path.
- Replaces the fixed hold-timer pacing with true backpressure. Adds per-command colour, linear address generation, screen clipping, a busy/done status pair and a pixel counter.

---
 rtl/line_raster_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_line_raster_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_raster_engine.sv
// line_raster_engine: all-octant Bresenham line rasteriser with screen clipping,
// linear framebuffer address generation and a valid/ready pixel write stream.
module line_raster_engine #(
    parameter int unsigned          COORD_W  = 16,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int                   FB_W     = 640,
    parameter int                   FB_H     = 480,
    parameter logic [ADDR_W-1:0]    FB_BASE  = '0,
    parameter int unsigned          BYTES_PP = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic [DATA_W-1:0]         color,
    output logic                      busy,
    output logic                      done,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [ADDR_W-1:0]         pix_addr,
    output logic [DATA_W-1:0]         pix_data,
    output logic [15:0]               pix_count
);

    // Delta (|d| up to 2^COORD_W-1), error term and doubled-error widths.
    localparam int unsigned DW     = COORD_W + 1;
    localparam int unsigned EW     = COORD_W + 2;
    localparam int unsigned E2W    = COORD_W + 3;
    localparam int unsigned BPP_SH = $clog2(BYTES_PP);

    localparam logic [ADDR_W-1:0]         STRIDE = ADDR_W'(FB_W);
    localparam logic signed [COORD_W-1:0] ONE    = COORD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic signed [COORD_W-1:0]   x1_q, x1_d;
    logic signed [COORD_W-1:0]   y1_q, y1_d;
    logic signed [COORD_W-1:0]   cur_x_q, cur_x_d;
    logic signed [COORD_W-1:0]   cur_y_q, cur_y_d;
    logic signed [DW-1:0]        dx_q, dx_d;
    logic signed [DW-1:0]        dy_q, dy_d;
    logic signed [EW-1:0]        err_q, err_d;
    logic                        sx_neg_q, sx_neg_d;
    logic                        sy_neg_q, sy_neg_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0]           pix_addr_q, pix_addr_d;
    logic [DATA_W-1:0]           pix_data_q, pix_data_d;
    logic [15:0]                 pix_count_q, pix_count_d;

    logic signed [DW-1:0]        diff_x, diff_y, abs_dx, abs_dy;
    logic signed [E2W-1:0]       e2;
    logic                        step_x, step_y;
    logic signed [COORD_W-1:0]   nxt_x, nxt_y;
    logic signed [EW-1:0]        nxt_err;
    logic                        cur_inb, nxt_inb, at_end;
    logic [ADDR_W-1:0]           cur_addr, nxt_addr;

    // Pixel lies inside the visible framebuffer.
    function automatic logic in_bounds(input logic signed [COORD_W-1:0] px,
                                       input logic signed [COORD_W-1:0] py);
        return (px >= 0) && (int'(px) < FB_W) && (py >= 0) && (int'(py) < FB_H);
    endfunction

    // Byte address of an in-bounds pixel, wrapped to ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(input logic signed [COORD_W-1:0] px,
                                                  input logic signed [COORD_W-1:0] py);
        logic [ADDR_W-1:0] lin;
        lin = ADDR_W'(py) * STRIDE + ADDR_W'(px);
        return FB_BASE + (lin << BPP_SH);
    endfunction

    // Setup deltas, next Bresenham step and clip/address of current and next pixel.
    always_comb begin
        diff_x  = DW'(x1_q) - DW'(cur_x_q);
        diff_y  = DW'(y1_q) - DW'(cur_y_q);
        abs_dx  = diff_x[DW-1] ? -diff_x : diff_x;
        abs_dy  = diff_y[DW-1] ? -diff_y : diff_y;
        e2      = {err_q, 1'b0};
        step_x  = (e2 >= E2W'(dy_q));
        step_y  = (e2 <= E2W'(dx_q));
        nxt_x   = cur_x_q;
        nxt_y   = cur_y_q;
        nxt_err = err_q;
        if (step_x) begin
            nxt_err = nxt_err + EW'(dy_q);
            nxt_x   = sx_neg_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
        end
        if (step_y) begin
            nxt_err = nxt_err + EW'(dx_q);
            nxt_y   = sy_neg_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
        end
        cur_inb  = in_bounds(cur_x_q, cur_y_q);
        nxt_inb  = in_bounds(nxt_x, nxt_y);
        cur_addr = addr_of(cur_x_q, cur_y_q);
        nxt_addr = addr_of(nxt_x, nxt_y);
        at_end   = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    end

    // Next-state and output register logic.
    always_comb begin
        logic resolve;
        state_d     = state_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;
        pix_count_d = pix_count_q;
        resolve     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    x1_d        = x1;
                    y1_d        = y1;
                    cur_x_d     = x0;
                    cur_y_d     = y0;
                    pix_data_d  = color;
                    pix_count_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d     = abs_dx;
                dy_d     = -abs_dy;
                err_d    = EW'(abs_dx) - EW'(abs_dy);
                sx_neg_d = !(cur_x_q < x1_q);
                sy_neg_d = !(cur_y_q < y1_q);
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                // A presented beat resolves on handshake; an unpresented pixel is
                // either loaded (first pixel) or resolved at once when clipped.
                if (pix_valid_q) begin
                    resolve = pix_ready;
                end else if (cur_inb) begin
                    pix_valid_d = 1'b1;
                    pix_addr_d  = cur_addr;
                end else begin
                    resolve = 1'b1;
                end

                if (resolve) begin
                    if (pix_valid_q && (pix_count_q != 16'hFFFF)) begin
                        pix_count_d = pix_count_q + 16'd1;
                    end
                    if (at_end) begin
                        pix_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cur_x_d     = nxt_x;
                        cur_y_d     = nxt_y;
                        err_d       = nxt_err;
                        pix_valid_d = nxt_inb;
                        if (nxt_inb) begin
                            pix_addr_d = nxt_addr;
                        end
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x1_q        <= '0;
            y1_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= '0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_valid_q <= pix_valid_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
            pix_count_q <= pix_count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_addr  = pix_addr_q;
    assign pix_data  = pix_data_q;
    assign pix_count = pix_count_q;

endmodule

// File: tb/tb_line_raster_engine.sv
// Self-checking bench for line_raster_engine: directed cases plus randomized
// lines with random backpressure, compared against an integer reference model.
module tb_line_raster_engine;

    localparam int FB_W = 640;
    localparam int FB_H = 480;
    localparam int BPP  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] x0, y0, x1, y1;
    logic [31:0]        color;
    logic               busy, done, pix_valid, pix_ready;
    logic [31:0]        pix_addr, pix_data;
    logic [15:0]        pix_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] want[$];

    line_raster_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: pixel list of the line, keeping only on-screen pixels as addresses.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1,
                         output int npix, output bit first_inb);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_q.delete();
        npix = 0;
        first_inb = 1'b0;
        x  = ax0;
        y  = ay0;
        dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx = (ax0 < ax1) ? 1 : -1;
        sy = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        forever begin
            if (x >= 0 && x < FB_W && y >= 0 && y < FB_H) begin
                if (npix == 0) first_inb = 1'b1;
                exp_q.push_back(32'((y * FB_W + x) * BPP));
            end
            npix++;
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Issue one command, drive pix_ready by mode (0 always, 1 random, 2 pattern)
    // and score beats, stall stability, timing and final status.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [31:0] col, input int mode, input bit hold);
        int c, first_v, done_c, p, npix;
        bit fib, stall, rdy;
        logic [31:0] paddr, pdata;
        bit pat[6];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        model(ax0, ay0, ax1, ay1, npix, fib);
        obs_q.delete();
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
        color = col;
        start = 1'b1;
        c = 0; first_v = -1; done_c = -1; p = 0; stall = 1'b0;
        paddr = '0; pdata = '0;
        while (done_c < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                if (!hold) start = 1'b0;
                check("busy_after_accept", 32'(busy), 32'd1);
            end
            if (stall) begin
                check("stall_valid", 32'(pix_valid), 32'd1);
                check("stall_addr", pix_addr, paddr);
                check("stall_data", pix_data, pdata);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (p < 6) ? pat[p] : 1'b1;
            endcase
            if (pix_valid) p++;
            pix_ready = rdy;
            if (pix_valid && first_v < 0) first_v = c;
            if (pix_valid && rdy) begin
                obs_q.push_back(pix_addr);
                check("beat_data", pix_data, col);
            end
            stall = pix_valid && !rdy;
            paddr = pix_addr;
            pdata = pix_data;
            if (done) done_c = c;
        end
        if (done_c < 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("pix_count", 32'(pix_count), 32'(exp_q.size()));
        check("beat_total", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("beat_addr", obs_q[i], exp_q[i]);
        end
        if (fib) check("first_valid_latency", 32'(first_v), 32'd3);
        else     check("no_early_valid", 32'(first_v == 3), 32'd0);
        if (mode == 0) check("done_cycle", 32'(done_c), 32'(2 + npix + int'(fib)));
    endtask

    task automatic check_list(input string tag, input logic [31:0] w[$]);
        check({tag, "_n"}, 32'(obs_q.size()), 32'(w.size()));
        for (int i = 0; i < w.size() && i < obs_q.size(); i++) begin
            check(tag, obs_q[i], w[i]);
        end
    endtask

    initial begin
        int nb, stalls, ax, ay;
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", pix_addr, 32'd0);
        check("rst_data", pix_data, 32'd0);
        check("rst_count", 32'(pix_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Horizontal run at the origin.
        run_cmd(0, 0, 3, 0, 32'h00FF_FFFF, 0, 1'b0);
        want = {32'h0, 32'h4, 32'h8, 32'hC};
        check_list("hline_addr", want);

        // Steep, negative direction.
        run_cmd(5, 5, 3, 0, 32'h0012_3456, 0, 1'b0);
        want = {32'h3214, 32'h2814, 32'h1E10, 32'h1410, 32'hA0C, 32'hC};
        check_list("steep_addr", want);

        // Backpressure pattern on a diagonal.
        run_cmd(0, 0, 2, 2, 32'hA5A5_0001, 2, 1'b0);
        want = {32'h0, 32'hA04, 32'h1408};
        check_list("bp_addr", want);

        // Partial and full clipping.
        run_cmd(-2, 0, 1, 0, 32'h0000_00C1, 0, 1'b0);
        want = {32'h0, 32'h4};
        check_list("clip_addr", want);
        run_cmd(700, 10, 710, 10, 32'h0000_00C2, 0, 1'b0);
        check("offscreen_beats", 32'(obs_q.size()), 32'd0);

        // Single point with start held through DONE, then back-to-back command.
        run_cmd(7, 9, 7, 9, 32'hDEAD_BEEF, 0, 1'b1);
        want = {32'h5A1C};
        check_list("point_addr", want);
        run_cmd(1, 1, 4, 2, 32'h0BAD_F00D, 0, 1'b0);

        // Reset while a beat is stalled mid-line.
        x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd10; y1 = 16'sd0; color = 32'h7777_7777;
        start = 1'b1;
        pix_ready = 1'b0;
        nb = 0; stalls = 0;
        for (int i = 0; i < 40 && stalls < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pix_valid && nb < 3) begin
                pix_ready = 1'b1;
                nb++;
            end else begin
                pix_ready = 1'b0;
                if (pix_valid && nb == 3) stalls++;
            end
        end
        check("pre_reset_count", 32'(pix_count), 32'd3);
        check("pre_reset_valid", 32'(pix_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(pix_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(pix_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(2, 3, 5, 4, 32'h0000_0042, 0, 1'b0);

        // Randomized lines around and across the screen edges.
        for (int n = 0; n < 25; n++) begin
            ax = int'($urandom_range(0, 700)) - 30;
            ay = int'($urandom_range(0, 540)) - 30;
            run_cmd(ax, ay,
                    ax + int'($urandom_range(0, 60)) - 30,
                    ay + int'($urandom_range(0, 60)) - 30,
                    $urandom, 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
